// File: rtl/votacao_pkg.sv
// Shared types and constants for the voting controller: FSM states, debug codes, tally width.
package votacao_pkg;

  localparam int unsigned LARG_VOTO = 3;
  localparam logic [2:0]  NENHUM    = 3'd7;

  typedef logic [LARG_VOTO-1:0] voto_t;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    BUSCA   = 3'd1,
    ESPERA  = 3'd2,
    APURA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [4:0] DB_INICIAL = 5'd0;
  localparam logic [4:0] DB_BUSCA   = 5'd1;
  localparam logic [4:0] DB_ESPERA  = 5'd2;
  localparam logic [4:0] DB_APURA   = 5'd3;
  localparam logic [4:0] DB_FIM     = 5'd4;

  function automatic logic [4:0] codigo_db(estado_t e);
    logic [4:0] r;
    r = DB_INICIAL;
    case (e)
      INICIAL: r = DB_INICIAL;
      BUSCA:   r = DB_BUSCA;
      ESPERA:  r = DB_ESPERA;
      APURA:   r = DB_APURA;
      FIM:     r = DB_FIM;
      default: r = DB_INICIAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apura_votos.sv
// Tally registers plus the one-seat-per-cycle scan that finds the unique maximum.
module apura_votos
  import votacao_pkg::*;
#(
  parameter int unsigned N_JOGADORES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpar,
  input  logic       votar,
  input  logic [2:0] alvo,
  input  logic       apurar,
  output logic       ultimo,
  output logic [2:0] vencedor,
  output logic       empate_res
);

  localparam logic [2:0] ULTIMO = 3'(N_JOGADORES - 1);

  voto_t      tally_q [N_JOGADORES];
  logic [2:0] idx_q;
  voto_t      max_q, max_d, atual;
  logic [2:0] pos_q, pos_d;
  logic       tie_q, tie_d;

  always_comb begin
    atual = tally_q[idx_q];
    max_d = max_q;
    pos_d = pos_q;
    tie_d = tie_q;
    if (idx_q == 3'd0) begin
      max_d = atual;
      pos_d = 3'd0;
      tie_d = 1'b0;
    end else if (atual > max_q) begin
      max_d = atual;
      pos_d = idx_q;
      tie_d = 1'b0;
    end else if (atual == max_q) begin
      tie_d = 1'b1;
    end
  end

  // Result is taken from the next-state view so it is ready on the last scan cycle.
  always_comb begin
    ultimo     = apurar && (idx_q == ULTIMO);
    vencedor   = pos_d;
    empate_res = 1'b0;
    if (max_d == '0 || tie_d) begin
      vencedor   = NENHUM;
      empate_res = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_JOGADORES; i++) tally_q[i] <= '0;
      idx_q <= '0;
      max_q <= '0;
      pos_q <= '0;
      tie_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_JOGADORES; i++) begin
        if (limpar) begin
          tally_q[i] <= '0;
        end else if (votar && alvo == 3'(i) && tally_q[i] != '1) begin
          tally_q[i] <= tally_q[i] + 1'b1;
        end
      end
      idx_q <= (apurar && !ultimo) ? idx_q + 3'd1 : 3'd0;
      if (apurar) begin
        max_q <= max_d;
        pos_q <= pos_d;
        tie_q <= tie_d;
      end
    end
  end

endmodule

// File: rtl/controle_votacao.sv
// Voting-round FSM: walks the seats, collects votes, then hands off to apura_votos.
// Define AUTOVOTO_EN to let a player vote for themself.
module controle_votacao
  import votacao_pkg::*;
#(
  parameter int unsigned N_JOGADORES = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic                   valido,
  input  logic [2:0]             jogador_escolhido,
  input  logic                   passa,
  output logic [2:0]             votante_atual,
  output logic                   aguardando,
  output logic                   fim,
  output logic [2:0]             eliminado,
  output logic                   empate,
  output logic [4:0]             db_estado
);

  localparam logic [2:0] ULTIMO = 3'(N_JOGADORES - 1);

  estado_t                estado_q, estado_d;
  logic [N_JOGADORES-1:0] vivos_q;
  logic [7:0]             vivos_ext;
  logic [2:0]             votante_q, votante_d;
  logic [2:0]             eliminado_q;
  logic                   empate_q;
  logic                   limpar, votar, apurar, ultimo, aceito, auto_ok;
  logic [2:0]             vencedor;
  logic                   empate_res;

  // Seats beyond N_JOGADORES read as dead, which also rejects out-of-range targets.
  assign vivos_ext = 8'(vivos_q);

`ifdef AUTOVOTO_EN
  assign auto_ok = 1'b1;
`else
  assign auto_ok = (jogador_escolhido != votante_q);
`endif

  assign aceito = valido && vivos_ext[jogador_escolhido] && auto_ok;

  always_comb begin
    estado_d  = estado_q;
    votante_d = votante_q;
    limpar    = 1'b0;
    votar     = 1'b0;
    apurar    = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          limpar    = 1'b1;
          votante_d = 3'd0;
          estado_d  = BUSCA;
        end
      end
      BUSCA: begin
        if (vivos_ext[votante_q]) begin
          estado_d = ESPERA;
        end else if (votante_q == ULTIMO) begin
          estado_d = APURA;
        end else begin
          votante_d = votante_q + 3'd1;
        end
      end
      ESPERA: begin
        if (aceito || passa) begin
          votar = aceito;
          if (votante_q == ULTIMO) begin
            estado_d = APURA;
          end else begin
            votante_d = votante_q + 3'd1;
            estado_d  = BUSCA;
          end
        end
      end
      APURA: begin
        apurar = 1'b1;
        if (ultimo) estado_d = FIM;
      end
      FIM:     estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= INICIAL;
      votante_q   <= 3'd0;
      vivos_q     <= '0;
      eliminado_q <= NENHUM;
      empate_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      votante_q <= votante_d;
      if (limpar) begin
        vivos_q     <= vivos;
        eliminado_q <= NENHUM;
        empate_q    <= 1'b0;
      end else if (ultimo) begin
        eliminado_q <= vencedor;
        empate_q    <= empate_res;
      end
    end
  end

  apura_votos #(
    .N_JOGADORES(N_JOGADORES)
  ) u_apura (
    .clock     (clock),
    .reset     (reset),
    .limpar    (limpar),
    .votar     (votar),
    .alvo      (jogador_escolhido),
    .apurar    (apurar),
    .ultimo    (ultimo),
    .vencedor  (vencedor),
    .empate_res(empate_res)
  );

  assign votante_atual = votante_q;
  assign aguardando    = (estado_q == ESPERA);
  assign fim           = (estado_q == FIM);
  assign eliminado     = eliminado_q;
  assign empate        = empate_q;
  assign db_estado     = codigo_db(estado_q);

endmodule

// File: tb/tb_controle_votacao.sv
// Scoreboard bench for controle_votacao: directed rounds plus random rounds vs a tally model.
module tb_controle_votacao;

  localparam int N = 5;

`ifdef AUTOVOTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         iniciar = 1'b0;
  logic [N-1:0] vivos = '0;
  logic         valido = 1'b0;
  logic [2:0]   jogador_escolhido = '0;
  logic         passa = 1'b0;
  logic [2:0]   votante_atual;
  logic         aguardando;
  logic         fim;
  logic [2:0]   eliminado;
  logic         empate;
  logic [4:0]   db_estado;

  always #5 clock = ~clock;

  controle_votacao #(.N_JOGADORES(N)) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .vivos            (vivos),
    .valido           (valido),
    .jogador_escolhido(jogador_escolhido),
    .passa            (passa),
    .votante_atual    (votante_atual),
    .aguardando       (aguardando),
    .fim              (fim),
    .eliminado        (eliminado),
    .empate           (empate),
    .db_estado        (db_estado)
  );

  int         total = 0;
  int         bad = 0;
  logic [3:0] sb_q[$];
  logic [3:0] mon_exp;
  int         tally_m[N];
  logic [N-1:0] mask_m;
  logic [7:0] seen_esp = '0;
  logic       prev_fim = 1'b0;

  task automatic check(string nome, int atual, int esperado);
    total++;
    if (atual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  // Monitor: every fim pulse consumes one expected result.
  always @(negedge clock) begin
    if (aguardando) seen_esp[votante_atual] = 1'b1;
    if (fim) begin
      check("fim_single_cycle", int'(prev_fim), 0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fim_unexpected: got fim with empty scoreboard, expected none");
      end else begin
        mon_exp = sb_q.pop_front();
        check("eliminado", int'(eliminado), int'(mon_exp[3:1]));
        check("empate", int'(empate), int'(mon_exp[0]));
      end
    end
    prev_fim = fim;
  end

  function automatic bit aceita(int seat, int alvo);
    return (alvo < N) && mask_m[alvo] && (AUTO || alvo != seat);
  endfunction

  function automatic logic [3:0] esperado();
    int mx = 0, cnt = 0, pos = 0;
    for (int i = 0; i < N; i++) begin
      if (tally_m[i] > mx) begin
        mx = tally_m[i];
        pos = i;
        cnt = 1;
      end else if (tally_m[i] == mx && mx > 0) begin
        cnt++;
      end
    end
    if (mx == 0 || cnt > 1) return {3'd7, 1'b1};
    return {3'(pos), 1'b0};
  endfunction

  task automatic start_round(logic [N-1:0] m);
    for (int i = 0; i < N; i++) tally_m[i] = 0;
    mask_m = m;
    seen_esp = '0;
    @(negedge clock);
    vivos = m;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_espera(int seat);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!aguardando && k < 40);
    check("espera_reached", int'(aguardando), 1);
    check("votante_atual", int'(votante_atual), seat);
  endtask

  task automatic acao(int seat, int alvo, bit v, bit p);
    bit acc;
    acc = v && aceita(seat, alvo);
    if (acc && tally_m[alvo] < 7) tally_m[alvo]++;
    valido = v;
    passa = p;
    jogador_escolhido = 3'(alvo);
    @(negedge clock);
    valido = 1'b0;
    passa = 1'b0;
    if (!(acc || p)) begin
      check("rejeitado_estado", int'(db_estado), 2);
      check("rejeitado_votante", int'(votante_atual), seat);
    end
  endtask

  task automatic finish_round();
    logic [3:0] e;
    int k = 0;
    e = esperado();
    sb_q.push_back(e);
    while (sb_q.size() != 0 && k < 80) begin
      @(negedge clock);
      k++;
    end
    check("fim_timeout_pending", sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(negedge clock);
    check("eliminado_hold", int'(eliminado), int'(e[3:1]));
    check("empate_hold", int'(empate), int'(e[0]));
    check("volta_inicial", int'(db_estado), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, apura_cnt, alvo;
    int bons[$];

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_db_estado", int'(db_estado), 0);
    check("rst_votante", int'(votante_atual), 0);
    check("rst_aguardando", int'(aguardando), 0);
    check("rst_fim", int'(fim), 0);
    check("rst_eliminado", int'(eliminado), 7);
    check("rst_empate", int'(empate), 0);
    reset = 1'b0;

    // Plain round; iniciar pulsed during APURA must be ignored
    start_round(5'b11111);
    wait_espera(0); acao(0, 2, 1, 0);
    wait_espera(1); acao(1, 2, 1, 0);
    wait_espera(2); acao(2, 3, 1, 0);
    wait_espera(3); acao(3, 2, 1, 0);
    wait_espera(4); acao(4, 0, 0, 1);
    check("apura_entrada", int'(db_estado), 3);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    finish_round();

    // Skipped dead seats, invalid votes, three-way tie
    start_round(5'b10101);
    wait_espera(0);
    acao(0, 6, 1, 0);
    acao(0, 1, 1, 0);
    acao(0, 2, 1, 0);
    wait_espera(2); acao(2, 4, 1, 0);
    wait_espera(4); acao(4, 0, 1, 0);
    finish_round();
    check("dead_seats_never_awaited", int'(seen_esp & 8'b0000_1010), 0);

    // Self-vote by player 0
    start_round(5'b11111);
    wait_espera(0);
    acao(0, 0, 1, 0);
    if (!aceita(0, 0)) acao(0, 0, 0, 1);
    for (int s = 1; s < N; s++) begin
      wait_espera(s);
      acao(s, 0, 0, 1);
    end
    finish_round();

    // valido and passa together: the vote counts
    start_round(5'b11111);
    wait_espera(0); acao(0, 1, 1, 1);
    for (int s = 1; s < N; s++) begin
      wait_espera(s);
      acao(s, 0, 0, 1);
    end
    finish_round();

    // Mid-round reset while player 3 is voting
    start_round(5'b11111);
    for (int s = 0; s < 3; s++) begin
      wait_espera(s);
      acao(s, 3, 1, 0);
    end
    wait_espera(3);
    #2 reset = 1'b1;
    #1;
    check("midrst_db_estado", int'(db_estado), 0);
    check("midrst_votante", int'(votante_atual), 0);
    check("midrst_aguardando", int'(aguardando), 0);
    check("midrst_eliminado", int'(eliminado), 7);
    check("midrst_empate", int'(empate), 0);
    @(negedge clock);
    reset = 1'b0;
    start_round(5'b11111);
    wait_espera(0); acao(0, 4, 1, 0);
    for (int s = 1; s < N; s++) begin
      wait_espera(s);
      acao(s, 0, 0, 1);
    end
    finish_round();

    // Empty mask: BUSCA over all seats, then exactly N cycles of APURA
    start_round('0);
    sb_q.push_back(esperado());
    cnt = 0;
    apura_cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
      if (db_estado == 5'd3) apura_cnt++;
    end while (!fim && cnt < 40);
    check("vazio_latencia_fim", cnt, 2 * N);
    check("vazio_ciclos_apura", apura_cnt, N);
    @(negedge clock);
    check("vazio_scoreboard", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(negedge clock);

    // Random rounds
    for (int r = 0; r < 40; r++) begin
      start_round(N'($urandom_range(31, 0)));
      for (int s = 0; s < N; s++) begin
        if (mask_m[s]) begin
          wait_espera(s);
          if ($urandom % 2 == 1) begin
            do alvo = $urandom_range(7, 0); while (aceita(s, alvo));
            acao(s, alvo, 1, 0);
          end
          if ($urandom % 2 == 1) begin
            acao(s, $urandom_range(7, 0), 1'($urandom % 2), 1);
          end else begin
            bons.delete();
            for (int t = 0; t < N; t++) if (aceita(s, t)) bons.push_back(t);
            if (bons.size() == 0) acao(s, 0, 0, 1);
            else acao(s, bons[$urandom % bons.size()], 1, 0);
          end
        end
      end
      finish_round();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
